// File: rtl/cam_capture_if.sv
// Camera-side byte bus and BRAM write-side bus of the capture block.
// The camera/bench end uses master; the capture block uses slave.
interface cam_capture_if;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        wr_en;
  logic [18:0] wr_address;
  logic [11:0] wr_data;
  logic        frame_done;
  logic        overflow;

  modport master (
    output cam_pclk, cam_vsync, cam_href, cam_data,
    input  wr_en, wr_address, wr_data, frame_done, overflow
  );

  modport slave (
    input  cam_pclk, cam_vsync, cam_href, cam_data,
    output wr_en, wr_address, wr_data, frame_done, overflow
  );
endinterface

// File: rtl/cam_capture.sv
// Captures RGB444 camera bytes in the sysclk domain and emits one BRAM write
// per pixel in raster order, with frame-done pulse and sticky overflow flag.
module cam_capture #(
  parameter int FRAME_PIXELS = 307200,
  parameter int LINE_PIXELS  = 640
) (
  input  logic          sysclk,
  input  logic          sysrst,
  input  logic          capture_en,
  cam_capture_if.slave  bus
);

  localparam int          LW        = $clog2(LINE_PIXELS + 1);
  localparam logic [18:0] FRAME_END = 19'(FRAME_PIXELS);
  localparam logic [LW-1:0] LINE_MAX = LW'(LINE_PIXELS);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [1:0]    r_pclkSync;
  logic [1:0]    r_vsyncSync;
  logic [1:0]    r_hrefSync;
  logic [7:0]    r_dataS1;
  logic [7:0]    r_dataS2;
  logic          r_pclkPrev;
  logic          r_vsyncPrev;
  logic          r_hrefPrev;

  logic          r_phase;
  logic [3:0]    r_red;
  logic [LW-1:0] r_lineCount;
  logic          r_wrEn;
  logic [18:0]   r_wrAddr;
  logic [11:0]   r_wrData;
  logic          r_frameDone;
  logic          r_overflow;

  logic          w_pclkRise;
  logic          w_byteValid;
  logic          w_vsyncRise;
  logic          w_vsyncFall;
  logic          w_hrefFall;
  logic          w_active;
  logic          w_frameStart;
  logic          w_frameEnd;

  // Data rides the same two stages as pclk/href so a byte lines up with its strobe.
  always_ff @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) begin
      r_pclkSync  <= '0;
      r_vsyncSync <= '0;
      r_hrefSync  <= '0;
      r_dataS1    <= '0;
      r_dataS2    <= '0;
      r_pclkPrev  <= 1'b0;
      r_vsyncPrev <= 1'b0;
      r_hrefPrev  <= 1'b0;
    end else begin
      r_pclkSync  <= {r_pclkSync[0], bus.cam_pclk};
      r_vsyncSync <= {r_vsyncSync[0], bus.cam_vsync};
      r_hrefSync  <= {r_hrefSync[0], bus.cam_href};
      r_dataS1    <= bus.cam_data;
      r_dataS2    <= r_dataS1;
      r_pclkPrev  <= r_pclkSync[1];
      r_vsyncPrev <= r_vsyncSync[1];
      r_hrefPrev  <= r_hrefSync[1];
    end
  end

  assign w_pclkRise  = r_pclkSync[1] & ~r_pclkPrev;
  assign w_byteValid = w_pclkRise & r_hrefSync[1];
  assign w_vsyncRise = r_vsyncSync[1] & ~r_vsyncPrev;
  assign w_vsyncFall = ~r_vsyncSync[1] & r_vsyncPrev;
  assign w_hrefFall  = ~r_hrefSync[1] & r_hrefPrev;

  always_ff @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (capture_en)  w_nextState = WAIT_VS;
      WAIT_VS: if (w_vsyncFall) w_nextState = ACTIVE;
      ACTIVE:  if (w_vsyncRise) w_nextState = capture_en ? WAIT_VS : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_active     = (r_state == ACTIVE);
    w_frameStart = (r_state == WAIT_VS) && w_vsyncFall;
    w_frameEnd   = (r_state == ACTIVE) && w_vsyncRise;
  end

  // A pixel that completes on a frame-ending cycle still writes, alongside frame_done.
  always_ff @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) begin
      r_phase     <= 1'b0;
      r_red       <= '0;
      r_lineCount <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_frameDone <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wrEn      <= 1'b0;
      r_frameDone <= w_frameEnd;
      if (r_wrEn && (r_wrAddr != FRAME_END)) r_wrAddr <= r_wrAddr + 19'd1;
      if (w_frameStart) begin
        r_wrAddr    <= '0;
        r_lineCount <= '0;
        r_phase     <= 1'b0;
        r_overflow  <= 1'b0;
      end else if (w_active) begin
        if (w_hrefFall) begin
          r_phase     <= 1'b0;
          r_lineCount <= '0;
        end else if (w_byteValid) begin
          if (!r_phase) begin
            r_red   <= r_dataS2[3:0];
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if ((r_lineCount == LINE_MAX) || (r_wrAddr == FRAME_END)) begin
              r_overflow <= 1'b1;
            end else begin
              r_wrEn      <= 1'b1;
              r_wrData    <= {r_red, r_dataS2};
              r_lineCount <= r_lineCount + LW'(1);
            end
          end
        end
      end
    end
  end

  assign bus.wr_en      = r_wrEn;
  assign bus.wr_address = r_wrAddr;
  assign bus.wr_data    = r_wrData;
  assign bus.frame_done = r_frameDone;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture using a small 3x8 frame; drives a camera
// byte stream and checks the recorded BRAM writes against hand-built lists.
module tb_cam_capture;

  localparam int FP = 24;
  localparam int LP = 8;

  logic sysclk = 1'b0;
  logic sysrst;
  logic capture_en;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;

  logic [18:0] addrQ[$];
  logic [11:0] dataQ[$];
  logic [18:0] expAddrQ[$];
  logic [11:0] expDataQ[$];

  cam_capture_if camIf();

  cam_capture #(.FRAME_PIXELS(FP), .LINE_PIXELS(LP)) dut (
    .sysclk     (sysclk),
    .sysrst     (sysrst),
    .capture_en (capture_en),
    .bus        (camIf)
  );

  always #5 sysclk = ~sysclk;

  // Record every write and every frame_done cycle, sampled just after the edge.
  always @(posedge sysclk) begin
    #1;
    if (camIf.wr_en === 1'b1) begin
      addrQ.push_back(camIf.wr_address);
      dataQ.push_back(camIf.wr_data);
    end
    if (camIf.frame_done === 1'b1) doneCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] expPix(input int k);
    return 12'(12'h1A3 + 12'(k) * 12'h0F7);
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    camIf.cam_data = b;
    camIf.cam_pclk = 1'b0;
    repeat (4) @(negedge sysclk);
    camIf.cam_pclk = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic sendPixel(input int k);
    logic [11:0] v;
    v = expPix(k);
    applyStimulus({4'h6, v[11:8]});
    applyStimulus(v[7:0]);
  endtask

  task automatic sendLine(input int base, input int n, input bit loneByte);
    camIf.cam_href = 1'b1;
    for (int j = 0; j < n; j++) sendPixel(base + j);
    if (loneByte) applyStimulus(8'h6F);
    camIf.cam_href = 1'b0;
    camIf.cam_pclk = 1'b0;
    repeat (8) @(negedge sysclk);
  endtask

  task automatic startFrame();
    addrQ.delete();
    dataQ.delete();
    doneCount = 0;
    camIf.cam_vsync = 1'b1;
    repeat (4) @(negedge sysclk);
    camIf.cam_vsync = 1'b0;
    repeat (8) @(negedge sysclk);
  endtask

  task automatic endFrame();
    camIf.cam_vsync = 1'b1;
    repeat (10) @(negedge sysclk);
  endtask

  task automatic expectRun(input int addr0, input int pix0, input int n);
    for (int j = 0; j < n; j++) begin
      expAddrQ.push_back(19'(addr0 + j));
      expDataQ.push_back(expPix(pix0 + j));
    end
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, ".count"}, 32'(addrQ.size()), 32'(expAddrQ.size()));
    n = (addrQ.size() < expAddrQ.size()) ? addrQ.size() : expAddrQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s.addr%0d", tag, i), 32'(addrQ[i]), 32'(expAddrQ[i]));
      checkOutput($sformatf("%s.data%0d", tag, i), 32'(dataQ[i]), 32'(expDataQ[i]));
    end
    expAddrQ.delete();
    expDataQ.delete();
  endtask

  initial begin
    sysrst          = 1'b0;
    capture_en      = 1'b0;
    camIf.cam_pclk  = 1'b0;
    camIf.cam_vsync = 1'b1;
    camIf.cam_href  = 1'b0;
    camIf.cam_data  = 8'h00;
    repeat (3) @(negedge sysclk);
    checkOutput("rst.wr_en",      32'(camIf.wr_en),      32'd0);
    checkOutput("rst.wr_address", 32'(camIf.wr_address), 32'd0);
    checkOutput("rst.wr_data",    32'(camIf.wr_data),    32'd0);
    checkOutput("rst.frame_done", 32'(camIf.frame_done), 32'd0);
    checkOutput("rst.overflow",   32'(camIf.overflow),   32'd0);
    sysrst = 1'b1;
    repeat (4) @(negedge sysclk);

    // Capture disabled: nothing written, no frame_done.
    startFrame();
    sendLine(0, 8, 1'b0);
    endFrame();
    compareWrites("disabled");
    checkOutput("disabled.done", 32'(doneCount), 32'd0);

    // Full frame of 3 lines x 8 pixels.
    capture_en = 1'b1;
    startFrame();
    sendLine(0, 8, 1'b0);
    sendLine(8, 8, 1'b0);
    sendLine(16, 8, 1'b0);
    endFrame();
    expectRun(0, 0, 24);
    compareWrites("full");
    checkOutput("full.done",     32'(doneCount),          32'd1);
    checkOutput("full.overflow", 32'(camIf.overflow),     32'd0);
    checkOutput("full.addrEnd",  32'(camIf.wr_address),   32'd24);

    // Line one pixel too long: ninth pixel dropped, next line continues at 8.
    startFrame();
    sendLine(0, 9, 1'b0);
    sendLine(16, 3, 1'b0);
    endFrame();
    expectRun(0, 0, 8);
    expectRun(8, 16, 3);
    compareWrites("longLine");
    checkOutput("longLine.overflow", 32'(camIf.overflow), 32'd1);
    checkOutput("longLine.done",     32'(doneCount),      32'd1);

    // href falls after 3 bytes: lone byte dropped, next line pairs correctly.
    startFrame();
    sendLine(0, 1, 1'b1);
    sendLine(10, 2, 1'b0);
    endFrame();
    expectRun(0, 0, 1);
    expectRun(1, 10, 2);
    compareWrites("lone");
    checkOutput("lone.overflow", 32'(camIf.overflow), 32'd0);
    checkOutput("lone.done",     32'(doneCount),      32'd1);

    // Extra pixels past the last address are dropped and the address saturates.
    startFrame();
    sendLine(0, 8, 1'b0);
    sendLine(8, 8, 1'b0);
    sendLine(16, 8, 1'b0);
    sendLine(24, 2, 1'b0);
    endFrame();
    expectRun(0, 0, 24);
    compareWrites("sat");
    checkOutput("sat.overflow", 32'(camIf.overflow),   32'd1);
    checkOutput("sat.addrEnd",  32'(camIf.wr_address), 32'd24);
    checkOutput("sat.done",     32'(doneCount),        32'd1);

    // Short frame, with capture_en dropped mid-frame: the frame still completes.
    startFrame();
    sendLine(0, 8, 1'b0);
    capture_en = 1'b0;
    sendLine(8, 2, 1'b0);
    endFrame();
    expectRun(0, 0, 10);
    compareWrites("short");
    checkOutput("short.done",     32'(doneCount),        32'd1);
    checkOutput("short.addrEnd",  32'(camIf.wr_address), 32'd10);
    checkOutput("short.overflow", 32'(camIf.overflow),   32'd0);

    startFrame();
    sendLine(0, 4, 1'b0);
    endFrame();
    compareWrites("disarmed");
    checkOutput("disarmed.done", 32'(doneCount), 32'd0);

    capture_en = 1'b1;
    repeat (4) @(negedge sysclk);
    startFrame();
    sendLine(30, 3, 1'b0);
    endFrame();
    expectRun(0, 30, 3);
    compareWrites("rearm");
    checkOutput("rearm.done", 32'(doneCount), 32'd1);

    // Asynchronous reset in the middle of a line aborts the frame.
    startFrame();
    camIf.cam_href = 1'b1;
    for (int j = 0; j < 5; j++) sendPixel(50 + j);
    repeat (6) @(negedge sysclk);
    checkOutput("preRst.addr", 32'(camIf.wr_address), 32'd5);
    @(negedge sysclk);
    #2;
    sysrst = 1'b0;
    #1;
    checkOutput("midRst.wr_en",      32'(camIf.wr_en),      32'd0);
    checkOutput("midRst.wr_address", 32'(camIf.wr_address), 32'd0);
    checkOutput("midRst.wr_data",    32'(camIf.wr_data),    32'd0);
    checkOutput("midRst.overflow",   32'(camIf.overflow),   32'd0);
    checkOutput("midRst.frame_done", 32'(camIf.frame_done), 32'd0);
    camIf.cam_href  = 1'b0;
    camIf.cam_pclk  = 1'b0;
    camIf.cam_vsync = 1'b1;
    repeat (4) @(negedge sysclk);
    sysrst = 1'b1;
    repeat (10) @(negedge sysclk);
    checkOutput("midRst.done", 32'(doneCount), 32'd0);

    startFrame();
    sendLine(40, 2, 1'b0);
    endFrame();
    expectRun(0, 40, 2);
    compareWrites("postRst");
    checkOutput("postRst.done", 32'(doneCount), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter FRAME_PIXELS, default 307200, pixels per frame (640x480); last valid address is FRAME_PIXELS-1.
REQ-002 Parameter LINE_PIXELS, default 640, maximum pixels written per line.
REQ-003 sysclk  in  1  system clock; must be at least 4x cam_pclk frequency.
REQ-004 sysrst  in  1  reset, asynchronous, active-low.
REQ-005 capture_en  in  1  high to arm capture at the next frame start.
REQ-006 cam_pclk  in  1  camera pixel clock, sampled as data.
REQ-007 cam_vsync  in  1  camera VSYNC, high between frames.
REQ-008 cam_href  in  1  camera HREF, high during valid line bytes.
REQ-009 cam_data  in  8  camera byte, RGB444 (byte 1 xxxxRRRR, byte 2 GGGGBBBB).
REQ-010 wr_en  out  1  BRAM write strobe, one sysclk per pixel.
REQ-011 wr_address  out  19  BRAM write address, same 0..FRAME_PIXELS-1 raster order the VGA read side uses.
REQ-012 wr_data  out  12  pixel {R,G,B}, 4 bits each.
REQ-013 frame_done  out  1  one-cycle pulse at end of a captured frame.
REQ-014 overflow  out  1  sticky flag: pixels dropped in current frame.

Function
REQ-015 cam_pclk, cam_vsync and cam_href SHALL each pass through a 2-flop synchronizer; cam_data SHALL be delayed by the same 2 stages so it stays aligned.
REQ-016 A pclk rising edge SHALL be detected when synchronized pclk is 1 and its previous value is 0; bytes are accepted only on that cycle with synchronized href high.
REQ-017 FSM states SHALL be IDLE, WAIT_VS, ACTIVE.
REQ-018 IDLE: go to WAIT_VS when capture_en=1.
REQ-019 WAIT_VS: on a synchronized vsync falling edge, go to ACTIVE; clear wr_address, line pixel count, byte phase and overflow.
REQ-020 ACTIVE: first accepted byte of a pair is stored in its low nibble (R); the second forms wr_data={R, byte[7:4], byte[3:0]}.
REQ-021 wr_en SHALL assert exactly one sysclk after the cycle accepting the second byte, with wr_data and wr_address valid in that same cycle.
REQ-022 wr_address SHALL increment by 1 in the cycle after each wr_en.
REQ-023 Byte phase and line pixel count SHALL reset on a synchronized href falling edge; a lone first byte at line end is discarded.
REQ-024 Pixels beyond LINE_PIXELS in a line, or once wr_address has reached FRAME_PIXELS, SHALL not be written, and overflow SHALL be set.
REQ-025 wr_address SHALL saturate at FRAME_PIXELS and never wrap within a frame.
REQ-026 In ACTIVE, a synchronized vsync rising edge SHALL pulse frame_done for 1 cycle, then go to WAIT_VS if capture_en=1, else IDLE.
REQ-027 If a vsync rising edge coincides with a write cycle, the write SHALL complete first and frame_done SHALL pulse in the same cycle.
REQ-028 When capture_en drops mid-frame, the current frame SHALL complete; it takes effect only at frame end.
REQ-029 A short frame (fewer than FRAME_PIXELS writes) SHALL still pulse frame_done; unwritten addresses keep their old contents.

Reset
REQ-030 While sysrst=0: FSM=IDLE; wr_en=0, wr_address=0, wr_data=0, frame_done=0, overflow=0; synchronizers and byte phase cleared.
REQ-031 Reset mid-frame SHALL take effect immediately (asynchronously) and abort the frame without a frame_done pulse.

Verification
REQ-032 capture_en=1, one full 640x480 frame, byte pairs 0x0A,0xBC -> 307200 wr_en pulses, wr_data=0xABC, addresses 0..307199 in order, one frame_done, overflow=0.
REQ-033 Line with 641 pixels -> 640 writes for that line, the next line starts at the next address, overflow=1.
REQ-034 href falls after 3 bytes -> 1 write, the third byte is discarded, and the next line's first pair forms a correct pixel.
REQ-035 capture_en=0 throughout a frame -> no wr_en, FSM stays IDLE, frame_done=0.
REQ-036 sysrst pulsed low at pixel 1000 -> outputs 0 at once; after release and re-arm, next frame writes from address 0.
REQ-037 vsync rises after 100 pixels -> frame_done pulses once, wr_address stops at 100, and the next frame restarts at 0.
